// File: rtl/write_address_generator_if.sv
// Write-address-generator bus: filter/IFMap write handshakes, row release and published row window.
interface write_address_generator_if #(
   parameter int FILTER_ADDR_WIDTH = 6,
   parameter int IFMAP_ADDR_WIDTH  = 5
);
   logic                         start;
   logic [FILTER_ADDR_WIDTH-1:0] filter_words;
   logic                         filter_valid;
   logic                         filter_ready;
   logic                         wen_Filter;
   logic [FILTER_ADDR_WIDTH-1:0] waddr_Filter;
   logic                         ifmap_valid;
   logic                         ifmap_last;
   logic                         ifmap_ready;
   logic                         wen_IFMap;
   logic [IFMAP_ADDR_WIDTH-1:0]  waddr_IFMap;
   logic                         row_done;
   logic [IFMAP_ADDR_WIDTH-1:0]  start_data;
   logic [IFMAP_ADDR_WIDTH-1:0]  end_data;
   logic                         valid_end;
   logic                         full;
   logic                         overflow;

   modport master (
      output start, filter_words, filter_valid, ifmap_valid, ifmap_last, row_done,
      input  filter_ready, wen_Filter, waddr_Filter, ifmap_ready, wen_IFMap, waddr_IFMap,
             start_data, end_data, valid_end, full, overflow
   );

   modport slave (
      input  start, filter_words, filter_valid, ifmap_valid, ifmap_last, row_done,
      output filter_ready, wen_Filter, waddr_Filter, ifmap_ready, wen_IFMap, waddr_IFMap,
             start_data, end_data, valid_end, full, overflow
   );
endinterface

// File: rtl/write_address_generator.sv
// Write-side scratchpad address generator: linear filter load, then circular IFMap row streaming
// with one published row and at most one prefetched row.
module write_address_generator #(
   parameter int FILTER_ADDR_WIDTH = 6,
   parameter int IFMAP_ADDR_WIDTH  = 5,
   parameter int IFMAP_DEPTH       = 32
) (
   input logic                      clk,
   input logic                      rst,
   write_address_generator_if.slave bus
);
   localparam int OW = IFMAP_ADDR_WIDTH + 1;
   localparam logic [IFMAP_ADDR_WIDTH-1:0] LAST_ADDR = IFMAP_ADDR_WIDTH'(IFMAP_DEPTH - 1);
   localparam logic [OW-1:0] DEPTH_CNT = OW'(IFMAP_DEPTH);
   localparam logic [OW-1:0] MAX_LEN_M1 = OW'(IFMAP_DEPTH - 1);

   typedef enum logic [2:0] {IDLE, FILTER, FIRST_ROW, PREFETCH, HOLD} state_t;

   state_t                       state, state_nxt;
   logic [FILTER_ADDR_WIDTH-1:0] fcnt, waddr_f;
   logic [IFMAP_ADDR_WIDTH-1:0]  waddr_i, rbase, pend_base, pend_end, start_data_r, end_data_r;
   logic [OW-1:0]                rlen, occ, occ_nxt, cur_len, pend_len;
   logic                         valid_end_r, full_r, overflow_r;
   logic                         filter_ready, ifmap_ready, wen_f, wen_i;
   logic                         last_wr, free, publish_now, hold_now, publish_pend;

   function automatic logic [IFMAP_ADDR_WIDTH-1:0] wrap_inc(input logic [IFMAP_ADDR_WIDTH-1:0] a);
      return (a == LAST_ADDR) ? '0 : a + IFMAP_ADDR_WIDTH'(1);
   endfunction

   assign filter_ready = (state == FILTER);
   assign ifmap_ready  = ((state == FIRST_ROW) || (state == PREFETCH)) && !full_r && !overflow_r;
   assign wen_f        = bus.filter_valid && filter_ready;
   assign wen_i        = bus.ifmap_valid && ifmap_ready;
   assign last_wr      = wen_i && bus.ifmap_last;
   // row_done only frees a row that is actually published
   assign free         = bus.row_done && valid_end_r;
   assign publish_now  = last_wr && (!valid_end_r || free);
   assign hold_now     = last_wr && valid_end_r && !free;
   assign publish_pend = free && (state == HOLD);
   assign occ_nxt      = occ + (wen_i ? OW'(1) : '0) - (free ? cur_len : '0);

   always_comb begin
      state_nxt = state;
      case (state)
         IDLE:      if (bus.start) state_nxt = (bus.filter_words != '0) ? FILTER : FIRST_ROW;
         FILTER:    if (wen_f && (waddr_f == fcnt - FILTER_ADDR_WIDTH'(1))) state_nxt = FIRST_ROW;
         FIRST_ROW: if (last_wr) state_nxt = PREFETCH;
         PREFETCH:  if (hold_now) state_nxt = HOLD;
         HOLD:      if (free) state_nxt = PREFETCH;
         default:   state_nxt = IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (!rst) begin
         state        <= IDLE;
         fcnt         <= '0;
         waddr_f      <= '0;
         waddr_i      <= '0;
         rbase        <= '0;
         rlen         <= '0;
         occ          <= '0;
         cur_len      <= '0;
         pend_base    <= '0;
         pend_end     <= '0;
         pend_len     <= '0;
         start_data_r <= '0;
         end_data_r   <= '0;
         valid_end_r  <= 1'b0;
         full_r       <= 1'b0;
         overflow_r   <= 1'b0;
      end else begin
         state  <= state_nxt;
         occ    <= occ_nxt;
         full_r <= (occ_nxt == DEPTH_CNT);
         if ((state == IDLE) && bus.start) begin
            fcnt    <= bus.filter_words;
            waddr_f <= '0;
         end
         if (wen_f) waddr_f <= waddr_f + FILTER_ADDR_WIDTH'(1);
         if (wen_i) begin
            waddr_i <= wrap_inc(waddr_i);
            if (bus.ifmap_last) begin
               rlen  <= '0;
               rbase <= wrap_inc(waddr_i);
            end else begin
               rlen <= rlen + OW'(1);
               if (rlen == MAX_LEN_M1) overflow_r <= 1'b1;
            end
         end
         // A completed row goes straight to the read side when nothing is published (or it is being freed)
         if (publish_now) begin
            start_data_r <= rbase;
            end_data_r   <= waddr_i;
            cur_len      <= rlen + OW'(1);
            valid_end_r  <= 1'b1;
         end else if (hold_now) begin
            pend_base <= rbase;
            pend_end  <= waddr_i;
            pend_len  <= rlen + OW'(1);
         end else if (publish_pend) begin
            start_data_r <= pend_base;
            end_data_r   <= pend_end;
            cur_len      <= pend_len;
         end else if (free) begin
            valid_end_r <= 1'b0;
         end
      end
   end

   assign bus.filter_ready = filter_ready;
   assign bus.wen_Filter   = wen_f;
   assign bus.waddr_Filter = waddr_f;
   assign bus.ifmap_ready  = ifmap_ready;
   assign bus.wen_IFMap    = wen_i;
   assign bus.waddr_IFMap  = waddr_i;
   assign bus.start_data   = start_data_r;
   assign bus.end_data     = end_data_r;
   assign bus.valid_end    = valid_end_r;
   assign bus.full         = full_r;
   assign bus.overflow     = overflow_r;
endmodule

// File: tb/tb_write_address_generator.sv
// Table-driven bench for write_address_generator (IFMAP_DEPTH=8, 4-bit IFMap addresses).
module tb_write_address_generator;
  localparam int FA = 6;
  localparam int IA = 4;

  typedef struct packed {
    logic          fr;
    logic          wf;
    logic [FA-1:0] waf;
    logic          ir;
    logic          wi;
    logic [IA-1:0] wai;
    logic [IA-1:0] sd;
    logic [IA-1:0] ed;
    logic          ve;
    logic          fu;
    logic          ov;
  } out_t;

  typedef struct {
    logic          rst_n;
    logic          start;
    logic [FA-1:0] fw;
    logic          fv;
    logic          iv;
    logic          il;
    logic          rd;
    out_t          exp;
  } vec_t;

  logic clk = 1'b0;
  logic rst;
  vec_t vecs[$];
  out_t exp_q[$];
  int   n_cmp = 0;
  int   n_bad = 0;

  write_address_generator_if #(.FILTER_ADDR_WIDTH(FA), .IFMAP_ADDR_WIDTH(IA)) bus ();

  write_address_generator #(
    .FILTER_ADDR_WIDTH(FA),
    .IFMAP_ADDR_WIDTH (IA),
    .IFMAP_DEPTH      (8)
  ) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: got no finish, want finish before 200000");
    $fatal(1, "watchdog");
  end

  function automatic out_t sample();
    out_t o;
    o.fr  = bus.filter_ready;
    o.wf  = bus.wen_Filter;
    o.waf = bus.waddr_Filter;
    o.ir  = bus.ifmap_ready;
    o.wi  = bus.wen_IFMap;
    o.wai = bus.waddr_IFMap;
    o.sd  = bus.start_data;
    o.ed  = bus.end_data;
    o.ve  = bus.valid_end;
    o.fu  = bus.full;
    o.ov  = bus.overflow;
    return o;
  endfunction

  task automatic add(input logic r, st, input logic [FA-1:0] fw, input logic fv, iv, il, rd,
                     input logic fr, wf, input logic [FA-1:0] waf, input logic ir, wi,
                     input logic [IA-1:0] wai, sd, ed, input logic ve, fu, ov);
    vec_t v;
    v.rst_n = r;  v.start = st; v.fw = fw; v.fv = fv; v.iv = iv; v.il = il; v.rd = rd;
    v.exp = '{fr: fr, wf: wf, waf: waf, ir: ir, wi: wi, wai: wai, sd: sd, ed: ed, ve: ve, fu: fu, ov: ov};
    vecs.push_back(v);
  endtask

  task automatic check(input string name, input out_t act, input out_t want);
    n_cmp++;
    if (act !== want) begin
      n_bad++;
      $display("FAIL %s: got %h want %h", name, act, want);
    end
  endtask

  task automatic drive_idle();
    bus.start = 1'b0; bus.filter_words = '0; bus.filter_valid = 1'b0;
    bus.ifmap_valid = 1'b0; bus.ifmap_last = 1'b0; bus.row_done = 1'b0;
  endtask

  initial begin
    out_t act, want;
    int   waited;
    rst = 1'b0;
    drive_idle();
    //   rst st fw fv iv il rd | fr wf waf ir wi wai sd ed ve fu ov
    add(0, 0, 0, 0, 0, 0, 0,   0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);  // reset state
    add(1, 1, 5, 0, 0, 0, 0,   0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);  // start, 5 filter words
    add(1, 0, 0, 1, 0, 0, 0,   1, 1, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    add(1, 0, 0, 0, 0, 0, 0,   1, 0, 1, 0, 0, 0, 0, 0, 0, 0, 0);  // bubble
    add(1, 0, 0, 1, 0, 0, 0,   1, 1, 1, 0, 0, 0, 0, 0, 0, 0, 0);
    add(1, 1, 2, 1, 0, 0, 0,   1, 1, 2, 0, 0, 0, 0, 0, 0, 0, 0);  // start ignored outside IDLE
    add(1, 0, 0, 1, 0, 0, 0,   1, 1, 3, 0, 0, 0, 0, 0, 0, 0, 0);
    add(1, 0, 0, 1, 0, 0, 0,   1, 1, 4, 0, 0, 0, 0, 0, 0, 0, 0);
    add(1, 0, 0, 1, 0, 0, 0,   0, 0, 5, 1, 0, 0, 0, 0, 0, 0, 0);  // FIRST_ROW
    add(1, 0, 0, 0, 1, 0, 0,   0, 0, 5, 1, 1, 0, 0, 0, 0, 0, 0);  // row of 3
    add(1, 0, 0, 0, 1, 0, 0,   0, 0, 5, 1, 1, 1, 0, 0, 0, 0, 0);
    add(1, 0, 0, 0, 1, 1, 0,   0, 0, 5, 1, 1, 2, 0, 0, 0, 0, 0);
    add(1, 0, 0, 0, 0, 0, 0,   0, 0, 5, 1, 0, 3, 0, 2, 1, 0, 0);  // published 0..2
    add(1, 0, 0, 0, 1, 0, 0,   0, 0, 5, 1, 1, 3, 0, 2, 1, 0, 0);  // row of 4
    add(1, 0, 0, 0, 1, 0, 0,   0, 0, 5, 1, 1, 4, 0, 2, 1, 0, 0);
    add(1, 0, 0, 0, 1, 0, 0,   0, 0, 5, 1, 1, 5, 0, 2, 1, 0, 0);
    add(1, 0, 0, 0, 1, 1, 0,   0, 0, 5, 1, 1, 6, 0, 2, 1, 0, 0);
    add(1, 0, 0, 0, 1, 0, 0,   0, 0, 5, 0, 0, 7, 0, 2, 1, 0, 0);  // HOLD
    add(1, 0, 0, 0, 0, 0, 1,   0, 0, 5, 0, 0, 7, 0, 2, 1, 0, 0);  // row_done
    add(1, 0, 0, 0, 0, 0, 0,   0, 0, 5, 1, 0, 7, 3, 6, 1, 0, 0);  // published 3..6
    add(1, 0, 0, 0, 1, 0, 1,   0, 0, 5, 1, 1, 7, 3, 6, 1, 0, 0);  // free with row in progress
    add(1, 0, 0, 0, 1, 0, 1,   0, 0, 5, 1, 1, 0, 3, 6, 0, 0, 0);  // wrap; row_done ignored
    add(1, 0, 0, 0, 1, 1, 0,   0, 0, 5, 1, 1, 1, 3, 6, 0, 0, 0);
    add(1, 0, 0, 0, 0, 0, 0,   0, 0, 5, 1, 0, 2, 7, 1, 1, 0, 0);  // published 7..1
    add(1, 0, 0, 0, 1, 0, 0,   0, 0, 5, 1, 1, 2, 7, 1, 1, 0, 0);
    add(1, 0, 0, 0, 1, 0, 0,   0, 0, 5, 1, 1, 3, 7, 1, 1, 0, 0);
    add(1, 0, 0, 0, 1, 0, 0,   0, 0, 5, 1, 1, 4, 7, 1, 1, 0, 0);  // occ 6 after this
    add(1, 0, 0, 0, 1, 0, 1,   0, 0, 5, 1, 1, 5, 7, 1, 1, 0, 0);  // write+free: occ 4
    add(1, 0, 0, 0, 1, 0, 0,   0, 0, 5, 1, 1, 6, 7, 1, 0, 0, 0);
    add(1, 0, 0, 0, 1, 0, 0,   0, 0, 5, 1, 1, 7, 7, 1, 0, 0, 0);
    add(1, 0, 0, 0, 1, 0, 0,   0, 0, 5, 1, 1, 0, 7, 1, 0, 0, 0);
    add(1, 0, 0, 0, 1, 1, 0,   0, 0, 5, 1, 1, 1, 7, 1, 0, 0, 0);  // 8-word row, occ 8
    add(1, 0, 0, 0, 1, 0, 0,   0, 0, 5, 0, 0, 2, 2, 1, 1, 1, 0);  // full
    add(1, 0, 0, 0, 1, 0, 1,   0, 0, 5, 0, 0, 2, 2, 1, 1, 1, 0);
    add(1, 0, 0, 0, 0, 0, 0,   0, 0, 5, 1, 0, 2, 2, 1, 0, 0, 0);  // freed, nothing prefetched
    for (int k = 0; k < 8; k++)                                    // 8 beats, no last
      add(1, 0, 0, 0, 1, 0, 0, 0, 0, 5, 1, 1, IA'((2 + k) % 8), 2, 1, 0, 0, 0);
    add(1, 0, 0, 0, 1, 0, 0,   0, 0, 5, 0, 0, 2, 2, 1, 0, 1, 1);  // 9th beat refused, overflow
    add(1, 0, 0, 0, 0, 0, 1,   0, 0, 5, 0, 0, 2, 2, 1, 0, 1, 1);  // row_done ignored
    add(1, 0, 0, 0, 1, 0, 0,   0, 0, 5, 0, 0, 2, 2, 1, 0, 1, 1);
    add(0, 0, 0, 0, 1, 0, 0,   0, 0, 5, 0, 0, 2, 2, 1, 0, 1, 1);  // reset sampled at next edge
    add(1, 0, 0, 0, 1, 0, 0,   0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);  // all cleared
    add(1, 1, 0, 0, 0, 0, 0,   0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);  // start, skip filter
    add(1, 0, 0, 0, 1, 1, 0,   0, 0, 0, 1, 1, 0, 0, 0, 0, 0, 0);  // 1-word row
    add(1, 0, 0, 0, 0, 0, 0,   0, 0, 0, 1, 0, 1, 0, 0, 1, 0, 0);

    repeat (2) @(posedge clk);
    for (int i = 0; i < vecs.size(); i++) begin
      @(posedge clk);
      #1;
      rst              = vecs[i].rst_n;
      bus.start        = vecs[i].start;
      bus.filter_words = vecs[i].fw;
      bus.filter_valid = vecs[i].fv;
      bus.ifmap_valid  = vecs[i].iv;
      bus.ifmap_last   = vecs[i].il;
      bus.row_done     = vecs[i].rd;
      exp_q.push_back(vecs[i].exp);
      @(negedge clk);
      act  = sample();
      want = exp_q.pop_front();
      check($sformatf("vec%0d", i), act, want);
    end

    // Free the 1-word row: valid_end must drop within a bounded number of cycles
    @(posedge clk);
    #1;
    drive_idle();
    bus.row_done = 1'b1;
    @(posedge clk);
    #1;
    bus.row_done = 1'b0;
    waited = 0;
    while (bus.valid_end !== 1'b0 && waited < 4) begin
      @(posedge clk);
      #1;
      waited++;
    end
    n_cmp++;
    if (bus.valid_end !== 1'b0) begin
      n_bad++;
      $display("FAIL release_timeout: got valid_end %b want 0", bus.valid_end);
    end
    want = '{fr: 0, wf: 0, waf: 0, ir: 1, wi: 0, wai: 1, sd: 0, ed: 0, ve: 0, fu: 0, ov: 0};
    @(negedge clk);
    check("after_release", sample(), want);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
